// File: rtl/caliptra_prim_onehot_sel_seq.sv
// rtl/caliptra_prim_onehot_sel_seq.sv - registered one-hot select sequencer feeding the one-hot checker (option: CALIPTRA_ONEHOT_SEL_REDUN_EN)
module caliptra_prim_onehot_sel_seq #(
    parameter int AddrWidth   = 5,
    parameter int OneHotWidth = 2 ** AddrWidth
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req_i,
    input  logic [AddrWidth-1:0]   addr_i,
    output logic                   gnt_o,
    output logic [OneHotWidth-1:0] oh_o,
    output logic [AddrWidth-1:0]   addr_o,
    output logic                   en_o,
    input  logic                   chk_err_i,
    output logic                   done_o,
    output logic                   fatal_err_o
);

    localparam int AW1 = AddrWidth + 1;
    // Index limit is widened by one bit so the range check cannot wrap.
    localparam logic [AddrWidth:0] OhLimit = AW1'(OneHotWidth);

`ifdef CALIPTRA_ONEHOT_SEL_REDUN_EN
    // Sparse codes, pairwise Hamming distance 3 or more.
    localparam int StateWidth = 5;
    localparam logic [StateWidth-1:0] StIdle  = 5'b10100;
    localparam logic [StateWidth-1:0] StIssue = 5'b01001;
    localparam logic [StateWidth-1:0] StError = 5'b11111;
`else
    localparam int StateWidth = 2;
    localparam logic [StateWidth-1:0] StIdle  = 2'b00;
    localparam logic [StateWidth-1:0] StIssue = 2'b01;
    localparam logic [StateWidth-1:0] StError = 2'b10;
`endif

    logic [StateWidth-1:0]  state_q;
    logic [StateWidth-1:0]  state_d;
    logic                   in_range;
    logic                   issue_load;
    logic                   shadow_err;
    logic [OneHotWidth-1:0] oh_dec;

    assign in_range   = {1'b0, addr_i} < OhLimit;
    // Only an accepted, in-range, error-free request from IDLE leads to ISSUE.
    assign issue_load = (state_d == StIssue);

`ifdef CALIPTRA_ONEHOT_SEL_REDUN_EN
    logic [AddrWidth-1:0] addr_shadow_q;

    // Shadow copy of the registered index, stored inverted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_shadow_q <= '1;
        end else if (issue_load) begin
            addr_shadow_q <= ~addr_i;
        end
    end

    assign shadow_err = (addr_o != ~addr_shadow_q);
`else
    assign shadow_err = 1'b0;
`endif

    // Binary index to one-hot select decode.
    always_comb begin
        oh_dec = '0;
        for (int i = 0; i < OneHotWidth; i++) begin
            oh_dec[i] = ({1'b0, addr_i} == AW1'(i));
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; any unrecognised encoding falls into ERROR.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (chk_err_i || shadow_err) begin
                    state_d = StError;
                end else if (req_i) begin
                    state_d = in_range ? StIssue : StError;
                end
            end
            StIssue: begin
                state_d = (chk_err_i || shadow_err) ? StError : StIdle;
            end
            StError: begin
                state_d = StError;
            end
            default: begin
                state_d = StError;
            end
        endcase
    end

    // FSM outputs; grant is masked by a checker error so ERROR wins over a request.
    always_comb begin
        gnt_o  = (state_q == StIdle) && !chk_err_i;
        done_o = (state_q == StIssue) && !chk_err_i && !shadow_err;
    end

    // Select vector, index and enable registers presented to the checker.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            oh_o   <= '0;
            en_o   <= 1'b0;
            addr_o <= '0;
        end else if (issue_load) begin
            oh_o   <= oh_dec;
            en_o   <= 1'b1;
            addr_o <= addr_i;
        end else begin
            oh_o   <= '0;
            en_o   <= 1'b0;
        end
    end

    // Sticky fatal flag, registered so it cannot glitch.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fatal_err_o <= 1'b0;
        end else if (state_d == StError) begin
            fatal_err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_caliptra_prim_onehot_sel_seq.sv
// tb/tb_caliptra_prim_onehot_sel_seq.sv - scoreboard bench for the one-hot select sequencer
module tb_caliptra_prim_onehot_sel_seq;

    typedef struct {
        logic [31:0] oh;
        logic [4:0]  addr;
        logic        done;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic [4:0]  addr_in = '0;
    logic        chk_err = 1'b0;
    logic        gnt, en, done, fatal;
    logic [31:0] oh;
    logic [4:0]  addr_out;

    logic        req2 = 1'b0;
    logic [4:0]  addr2_in = '0;
    logic        chk_err2 = 1'b0;
    logic        gnt2, en2, done2, fatal2;
    logic [19:0] oh2;
    logic [4:0]  addr2_out;

    int n_vec = 0;
    int n_fail = 0;
    exp_t q[$];
    exp_t q2[$];
    exp_t me, me2;

    always #5 clk = ~clk;

    caliptra_prim_onehot_sel_seq dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .addr_i(addr_in),
        .gnt_o(gnt), .oh_o(oh), .addr_o(addr_out), .en_o(en),
        .chk_err_i(chk_err), .done_o(done), .fatal_err_o(fatal)
    );

    caliptra_prim_onehot_sel_seq #(.AddrWidth(5), .OneHotWidth(20)) dut_oor (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req2), .addr_i(addr2_in),
        .gnt_o(gnt2), .oh_o(oh2), .addr_o(addr2_out), .en_o(en2),
        .chk_err_i(chk_err2), .done_o(done2), .fatal_err_o(fatal2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor for the default-size instance: every issued select pops one expectation.
    always @(negedge clk) begin
        if (rst_n && en) begin
            if (q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_issue: got oh=%0h expected no issue", oh);
            end else begin
                me = q.pop_front();
                check("issue_oh", oh, me.oh);
                check("issue_addr", {27'd0, addr_out}, {27'd0, me.addr});
                check("issue_done", {31'd0, done}, {31'd0, me.done});
            end
        end
    end

    // Monitor for the 20-line instance.
    always @(negedge clk) begin
        if (rst_n && en2) begin
            if (q2.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_issue2: got oh=%0h expected no issue", oh2);
            end else begin
                me2 = q2.pop_front();
                check("issue2_oh", {12'd0, oh2}, me2.oh);
                check("issue2_addr", {27'd0, addr2_out}, {27'd0, me2.addr});
                check("issue2_done", {31'd0, done2}, {31'd0, me2.done});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_gnt", {31'd0, gnt}, 32'd1);
        check("rst_oh", oh, 32'd0);
        check("rst_addr", {27'd0, addr_out}, 32'd0);
        check("rst_en", {31'd0, en}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_fatal", {31'd0, fatal}, 32'd0);
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #1;
        do_reset();

        // Single request, index 5.
        req = 1'b1; addr_in = 5'd5;
        q.push_back('{32'h20, 5'd5, 1'b1});
        @(negedge clk); check("t1_gnt_c0", {31'd0, gnt}, 32'd1);
        tick(); req = 1'b0;
        @(negedge clk); check("t1_gnt_c1", {31'd0, gnt}, 32'd0);
        tick();
        @(negedge clk);
        check("t1_oh_c2", oh, 32'd0);
        check("t1_gnt_c2", {31'd0, gnt}, 32'd1);

        // Request held high with indices 0,1,2: grants every other cycle.
        tick();
        req = 1'b1; addr_in = 5'd0;
        for (int i = 0; i < 3; i++) begin
            q.push_back('{32'd1 << i, 5'(i), 1'b1});
            @(negedge clk); check("t2_gnt_idle", {31'd0, gnt}, 32'd1);
            tick(); addr_in = 5'(i + 1);
            @(negedge clk); check("t2_gnt_issue", {31'd0, gnt}, 32'd0);
            tick();
        end
        req = 1'b0;

        // Checker error during ISSUE.
        req = 1'b1; addr_in = 5'd7;
        q.push_back('{32'h80, 5'd7, 1'b0});
        @(negedge clk);
        tick(); req = 1'b0; chk_err = 1'b1;
        @(negedge clk);
        tick(); chk_err = 1'b0;
        @(negedge clk);
        check("t3_fatal", {31'd0, fatal}, 32'd1);
        check("t3_oh", oh, 32'd0);
        check("t3_en", {31'd0, en}, 32'd0);
        check("t3_gnt", {31'd0, gnt}, 32'd0);
        tick(); req = 1'b1; addr_in = 5'd2;
        @(negedge clk); check("t3_ignore_gnt", {31'd0, gnt}, 32'd0);
        tick();
        @(negedge clk);
        check("t3_ignore_en", {31'd0, en}, 32'd0);
        check("t3_still_fatal", {31'd0, fatal}, 32'd1);
        tick(); req = 1'b0;
        do_reset();

        // Checker error together with a request in IDLE: error wins.
        req = 1'b1; addr_in = 5'd1; chk_err = 1'b1;
        @(negedge clk); check("t4_gnt_masked", {31'd0, gnt}, 32'd0);
        tick(); req = 1'b0; chk_err = 1'b0;
        @(negedge clk);
        check("t4_fatal", {31'd0, fatal}, 32'd1);
        check("t4_en", {31'd0, en}, 32'd0);
        tick();
        do_reset();

        // Asynchronous reset mid-ISSUE: no done pulse, outputs clear at once.
        req = 1'b1; addr_in = 5'd4;
        tick(); req = 1'b0;
        #1;
        check("t5_en_issue", {31'd0, en}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("t5_oh_async", oh, 32'd0);
        check("t5_en_async", {31'd0, en}, 32'd0);
        check("t5_done_async", {31'd0, done}, 32'd0);
        tick(); rst_n = 1'b1;
        tick();

        // Flip one bit of the registered index while IDLE.
        force dut.addr_o = 5'h01;
        tick();
        @(negedge clk);
`ifdef CALIPTRA_ONEHOT_SEL_REDUN_EN
        check("t6_fatal_redun", {31'd0, fatal}, 32'd1);
        tick(); release dut.addr_o;
        do_reset();
`else
        check("t6_fatal_plain", {31'd0, fatal}, 32'd0);
        tick(); release dut.addr_o;
`endif
        req = 1'b1; addr_in = 5'd3;
        q.push_back('{32'h8, 5'd3, 1'b1});
        @(negedge clk); check("t6_gnt", {31'd0, gnt}, 32'd1);
        tick(); req = 1'b0;
        tick();
        @(negedge clk); check("t6_no_fatal", {31'd0, fatal}, 32'd0);

        // 20-line instance: top valid index, then out-of-range index.
        tick();
        req2 = 1'b1; addr2_in = 5'd19;
        q2.push_back('{32'h80000, 5'd19, 1'b1});
        @(negedge clk); check("t7_gnt_19", {31'd0, gnt2}, 32'd1);
        tick(); addr2_in = 5'd20;
        @(negedge clk); check("t7_gnt_issue", {31'd0, gnt2}, 32'd0);
        tick();
        @(negedge clk); check("t7_gnt_20", {31'd0, gnt2}, 32'd1);
        tick(); addr2_in = 5'd3;
        @(negedge clk);
        check("t7_fatal", {31'd0, fatal2}, 32'd1);
        check("t7_en", {31'd0, en2}, 32'd0);
        check("t7_gnt_err", {31'd0, gnt2}, 32'd0);
        tick();
        @(negedge clk);
        check("t7_en_later", {31'd0, en2}, 32'd0);
        check("t7_oh_later", {12'd0, oh2}, 32'd0);
        check("t7_fatal_later", {31'd0, fatal2}, 32'd1);
        tick(); req2 = 1'b0;

        repeat (2) tick();
        check("sb_empty", q.size(), 32'd0);
        check("sb2_empty", q2.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
